// File: rtl/reduceron_trace_pkg.sv
// Shared constants and record layout for the Reduceron run-status trace transmitter.
package reduceron_trace_pkg;

  localparam int unsigned RECORD_BYTES = 8;

  localparam int unsigned EV_GC_START  = 0;
  localparam int unsigned EV_GC_FINISH = 1;
  localparam int unsigned EV_HP        = 2;
  localparam int unsigned EV_FINISH    = 3;
  localparam int unsigned EV_LOST      = 7;

  // Field order is the on-wire byte order, most significant byte first.
  typedef struct packed {
    logic [7:0]  mask;
    logic [15:0] cycle;
    logic [15:0] hp;
    logic [15:0] result;
    logic [7:0]  state;
  } trace_rec_t;

  function automatic logic [7:0] rec_byte(trace_rec_t rec, logic [2:0] idx);
    logic [7:0] b;
    unique case (idx)
      3'd0: b = rec.mask;
      3'd1: b = rec.cycle[15:8];
      3'd2: b = rec.cycle[7:0];
      3'd3: b = rec.hp[15:8];
      3'd4: b = rec.hp[7:0];
      3'd5: b = rec.result[15:8];
      3'd6: b = rec.result[7:0];
      3'd7: b = rec.state;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/reduceron_trace_tx_fifo.sv
// Synchronous record FIFO with simultaneous push/pop; head is visible combinationally.
module trace_fifo
  import reduceron_trace_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic       pop_i,
  input  trace_rec_t wdata_i,
  output trace_rec_t rdata_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       single_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] FullCount = Depth[AW:0];
  localparam logic [AW:0] OneCount  = {{AW{1'b0}}, 1'b1};

  trace_rec_t      mem_q [Depth];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            do_pop;

  assign do_pop   = pop_i && (count_q != '0);
  assign rdata_o  = mem_q[rd_ptr_q];
  assign full_o   = (count_q == FullCount);
  assign empty_o  = (count_q == '0);
  assign single_o = (count_q == OneCount);

  always_comb begin
    count_d = count_q;
    if (push_i && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_i && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: contents are only observed while count_q says they are valid.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/reduceron_trace_tx.sv
// Captures Reduceron GC, heap-pointer and finish events as timestamped 8-byte records
// and streams them out byte-wise over a valid/ready link.
module reduceron_trace_tx
  import reduceron_trace_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] r,
  input  logic [6:0]  s,
  input  logic [12:0] h,
  input  logic        finish,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        overflow,
  output logic        done
);

  localparam logic [2:0] LastIdx = 3'(RECORD_BYTES - 1);

  typedef enum logic [0:0] {StIdle, StSend} ser_state_e;

  logic [15:0] cycle_q;
  logic        gc_q;
  logic [12:0] hp_q;
  logic        captured_finish_q, lost_pending_q, overflow_q, done_q;
  ser_state_e  state_q;
  logic [2:0]  idx_q;
  logic        valid_q;

  logic [7:0]  ev_mask;
  logic        capture, push, pop, drop, avail_next;
  logic        fifo_full, fifo_empty, fifo_single;
  trace_rec_t  rec_d, head;

  always_comb begin
    ev_mask               = '0;
    ev_mask[EV_GC_START]  = s[5] & ~gc_q;
    ev_mask[EV_GC_FINISH] = ~s[5] & gc_q;
    ev_mask[EV_HP]        = (h != hp_q);
    ev_mask[EV_FINISH]    = finish;
    ev_mask[EV_LOST]      = lost_pending_q;
  end

  always_comb begin
    rec_d.mask   = ev_mask;
    rec_d.cycle  = cycle_q;
    rec_d.hp     = {3'b000, h};
    rec_d.result = r;
    rec_d.state  = {1'b0, s};
  end

  assign capture = ~captured_finish_q & (|ev_mask[3:0]);
  assign pop     = valid_q & tx_ready & (idx_q == LastIdx);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push    = capture & (~fifo_full | pop);
  assign drop    = capture & fifo_full & ~pop;
  assign avail_next = push | (~fifo_empty & ~(pop & fifo_single));

  trace_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (rec_d),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .single_o(fifo_single)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q           <= '0;
      gc_q              <= 1'b0;
      hp_q              <= '0;
      captured_finish_q <= 1'b0;
      lost_pending_q    <= 1'b0;
      overflow_q        <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
      gc_q    <= s[5];
      hp_q    <= h;
      if (capture && finish) captured_finish_q <= 1'b1;
      if (drop) begin
        lost_pending_q <= 1'b1;
        overflow_q     <= 1'b1;
      end else if (push) begin
        lost_pending_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (avail_next) begin
            state_q <= StSend;
            idx_q   <= '0;
            valid_q <= 1'b1;
          end
        end
        StSend: begin
          if (valid_q && tx_ready) begin
            if (idx_q == LastIdx) begin
              if (head.mask[EV_FINISH]) done_q <= 1'b1;
              idx_q <= '0;
              if (!avail_next) begin
                state_q <= StIdle;
                valid_q <= 1'b0;
              end
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx_valid = valid_q;
  assign tx_data  = valid_q ? rec_byte(head, idx_q) : 8'h00;
  assign overflow = overflow_q;
  assign done     = done_q;

endmodule

// File: tb/tb_reduceron_trace_tx.sv
// Directed bench for reduceron_trace_tx: record contents, latency, overflow, stalls,
// finish handling and mid-record reset.
module tb_reduceron_trace_tx;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] r;
  logic [6:0]  s;
  logic [12:0] h;
  logic        finish;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        overflow;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  reduceron_trace_tx #(
    .FIFO_DEPTH(4)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .r       (r),
    .s       (s),
    .h       (h),
    .finish  (finish),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .overflow(overflow),
    .done    (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  function automatic logic [63:0] mkrec(logic [7:0] m, logic [15:0] c, logic [12:0] hh,
                                        logic [15:0] rr, logic [6:0] ss);
    return {m, c, 3'b000, hh, rr, 1'b0, ss};
  endfunction

  task automatic do_reset(input string tag);
    h        = '0;
    s        = 7'h11;
    finish   = 1'b0;
    tx_ready = 1'b0;
    reset_n  = 1'b0;
    #1;
    check({tag, " valid"}, tx_valid, 0);
    check({tag, " data"}, tx_data, 0);
    check({tag, " overflow"}, overflow, 0);
    check({tag, " done"}, done, 0);
    step();
    step();
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  // Receives one record; optionally stalls before every byte and optionally changes h
  // just before the byte-7 handshake (returns the cycle that change is sampled in).
  task automatic recv(input string tag, input logic [63:0] exp, input bit imm,
                      input bit toggle, input bit hook, input logic [12:0] hook_h,
                      output int hook_cyc);
    logic [7:0] b;
    int n;
    hook_cyc = 0;
    tx_ready = 1'b1;
    if (!imm) begin
      n = 0;
      while (!tx_valid && n < 40) begin
        step();
        n++;
      end
    end
    for (int i = 0; i < 8; i++) begin
      b = 8'(exp >> (8 * (7 - i)));
      if (toggle) begin
        tx_ready = 1'b0;
        step();
        check($sformatf("%s stall valid b%0d", tag, i), tx_valid, 1);
        check($sformatf("%s stall data b%0d", tag, i), tx_data, b);
        tx_ready = 1'b1;
      end
      check($sformatf("%s valid b%0d", tag, i), tx_valid, 1);
      check($sformatf("%s data b%0d", tag, i), tx_data, b);
      if (hook && i == 7) begin
        h        = hook_h;
        hook_cyc = cyc;
      end
      step();
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int c, c0, hc, dummy;
    bit any;
    r        = 16'h1234;
    s        = 7'h11;
    h        = '0;
    finish   = 1'b0;
    tx_ready = 1'b0;

    do_reset("reset");
    check("post-reset valid", tx_valid, 0);

    // Heap-pointer change at cycle 10.
    repeat (10) step();
    h = 13'h040;
    step();
    check("hp latency", tx_valid, 1);
    recv("hp", mkrec(8'h04, 16'h000A, 13'h040, 16'h1234, 7'h11), 1, 0, 0, '0, dummy);

    // GC start merged with hp change, then GC finish.
    while (cyc < 20) step();
    c = cyc;
    s = 7'h31;
    h = 13'h041;
    step();
    recv("gcstart", mkrec(8'h05, 16'(c), 13'h041, 16'h1234, 7'h31), 1, 0, 0, '0, dummy);
    while (cyc < 30) step();
    c = cyc;
    s = 7'h11;
    step();
    recv("gcfin", mkrec(8'h02, 16'(c), 13'h041, 16'h1234, 7'h11), 1, 0, 0, '0, dummy);

    // Six hp events with the sink stalled: four held, two dropped.
    tx_ready = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 6; i++) begin
      h = 13'h050 + 13'(i);
      step();
      if (i == 3) check("overflow before drop", overflow, 0);
      if (i == 4) check("overflow after drop", overflow, 1);
    end
    step();
    check("held valid", tx_valid, 1);
    // Event on the byte-7 pop edge with FIFO full must be accepted and carry the lost flag.
    recv("ov0", mkrec(8'h04, 16'(c0), 13'h050, 16'h1234, 7'h11), 1, 0, 1, 13'h058, hc);
    recv("ov1", mkrec(8'h04, 16'(c0 + 1), 13'h051, 16'h1234, 7'h11), 1, 1, 0, '0, dummy);
    recv("ov2", mkrec(8'h04, 16'(c0 + 2), 13'h052, 16'h1234, 7'h11), 1, 1, 0, '0, dummy);
    recv("ov3", mkrec(8'h04, 16'(c0 + 3), 13'h053, 16'h1234, 7'h11), 1, 0, 0, '0, dummy);
    recv("lost", mkrec(8'h84, 16'(hc), 13'h058, 16'h1234, 7'h11), 1, 0, 0, '0, dummy);
    check("idle after drain", tx_valid, 0);
    check("overflow sticky", overflow, 1);
    c = cyc;
    h = 13'h059;
    step();
    recv("lost cleared", mkrec(8'h04, 16'(c), 13'h059, 16'h1234, 7'h11), 1, 0, 0, '0, dummy);

    // Finish record, then further events must be ignored.
    tx_ready = 1'b0;
    while (cyc < 100) step();
    c      = cyc;
    r      = 16'h0029;
    finish = 1'b1;
    step();
    finish = 1'b0;
    h      = 13'h070;
    step();
    h = 13'h071;
    step();
    check("done before finish tx", done, 0);
    recv("finish", mkrec(8'h08, 16'(c), 13'h059, 16'h0029, 7'h11), 1, 0, 0, '0, dummy);
    check("done after finish tx", done, 1);
    any = 1'b0;
    repeat (20) begin
      h = h + 13'h1;
      step();
      if (tx_valid) any = 1'b1;
    end
    check("no records after finish", any, 0);
    check("done sticky", done, 1);

    // Reset clears done; then a reset pulse in the middle of a record.
    do_reset("reset2");
    repeat (5) step();
    h = 13'h022;
    step();
    tx_ready = 1'b1;
    check("mid valid", tx_valid, 1);
    check("mid byte0", tx_data, 8'h04);
    step();
    step();
    step();
    check("mid byte3 valid", tx_valid, 1);
    check("mid byte3", tx_data, 8'h00);
    reset_n = 1'b0;
    #1;
    check("midrst valid", tx_valid, 0);
    check("midrst data", tx_data, 0);
    check("midrst overflow", overflow, 0);
    check("midrst done", done, 0);
    step();
    reset_n = 1'b1;
    cyc     = 0;
    tx_ready = 1'b0;
    step();
    check("restart latency", tx_valid, 1);
    recv("restart", mkrec(8'h04, 16'h0000, 13'h022, 16'h0029, 7'h11), 1, 0, 0, '0, dummy);
    check("restart idle", tx_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reduceron_trace_tx.md
# reduceron_trace_tx

Synthesizable on-FPGA transmitter for Reduceron run-status events, replacing simulation-only `$display` monitoring in hardware builds. It samples the core's result, state, heap-pointer and finish outputs every cycle. It captures GC start/finish, heap-pointer changes and run completion as timestamped 8-byte records. Records are buffered and streamed out as bytes over a valid/ready interface to a UART or host link.

## Interface

Parameters:
- `FIFO_DEPTH`, default 4: record slots; power of two, at least 2.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `r`  in  16  result word; `r[2:0]` tag, `r[15:3]` value.
- `s`  in  7  core state; `s[5]` = GC active.
- `h`  in  13  heap pointer.
- `finish`  in  1  run complete.
- `tx_data`  out  8  current record byte.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  sink accepts the byte on a cycle where `tx_valid` is also high.
- `overflow`  out  1  sticky: at least one record dropped since reset.
- `done`  out  1  finish record fully transmitted.

## Operation

- Free-running 16-bit `cycle` counter: 0 after reset, +1 every clock, wraps 0xFFFF→0.
- Registered history `gc_q` (from `s[5]`) and `hp_q` (from `h`), both reset to 0. They update every cycle regardless of capture.
- Event mask, evaluated each cycle while `captured_finish`=0:
  - bit0 = `s[5] & ~gc_q` (GC start).
  - bit1 = `~s[5] & gc_q` (GC finish).
  - bit2 = `h != hp_q`.
  - bit3 = `finish`.
  - bit7 = lost flag.
  - bits 6:4 = 0.
- A nonzero mask in bits 3:0 generates exactly one record for that cycle. Several events in the same cycle are merged into one record.
- The first `finish` sets `captured_finish`. No further records are generated until reset.
- Record byte order:
  1. mask
  2. `cycle[15:8]`
  3. `cycle[7:0]`
  4. `{3'b0,h[12:8]}`
  5. `h[7:0]`
  6. `r[15:8]`
  7. `r[7:0]`
  8. `{1'b0,s}`
- All fields carry the values sampled in the capture cycle.
- FIFO full at the capture edge:
  - The record is dropped.
  - `overflow` is set.
  - `lost_pending` is set.
  - The next accepted record carries bit7=1, and that push clears `lost_pending`.
- Serializer states:
  - IDLE: when the FIFO is non-empty, go to SEND with byte index 0.
  - SEND: a handshake advances the index. On a handshake at index 7, pop the head, then go to SEND with index 0 if the FIFO is still non-empty, otherwise IDLE.
- `done` is set on the handshake of byte 7 of the record whose mask has bit3 set. It stays set until reset.

## Timing

- Reset values: `tx_data`=0, `tx_valid`=0, `overflow`=0, `done`=0. FIFO empty, counters 0, serializer IDLE.
- Latency: an event sampled at edge N with the FIFO empty and the serializer IDLE drives `tx_valid`=1 with the mask byte from cycle N+1.
- `tx_data` is held stable while `tx_valid`=1 and `tx_ready`=0. `tx_valid` never drops without a handshake, except on reset.
- A record occupies its FIFO slot until its byte 7 is accepted. Capacity is exactly `FIFO_DEPTH` records.
- Push and pop in the same cycle with the FIFO full: the push is accepted.
- Back-to-back records with `tx_ready` held high: byte 7 of record k is followed immediately by byte 0 of record k+1, with no bubble.
- `reset_n` asserted mid-record: output stops immediately and all state clears. Partial records are not resumed.

## Structure

- Package `reduceron_trace_pkg` holds:
  - `RECORD_BYTES`=8.
  - Mask bit index constants (`EV_GC_START`, `EV_GC_FINISH`, `EV_HP`, `EV_FINISH`, `EV_LOST`).
  - Packed 64-bit record typedef `trace_rec_t`.
- Sub-module `trace_fifo`: synchronous FIFO of `trace_rec_t` with full/empty flags and simultaneous push/pop.
- Top level holds edge detection, record assembly, overflow tracking and the byte serializer.

## Test plan

- Reset, then `h` 0→0x0040 at cycle 10, `tx_ready`=1 → bytes `04 00 0A 00 40 r_hi r_lo s` starting cycle 11, 8 consecutive cycles.
- `s[5]` 0→1 and `h` 0x40→0x41 on the same edge at cycle 20 → one record, mask 0x05. `s[5]` 1→0 at cycle 30 → mask 0x02.
- `tx_ready`=0 while 6 single-cycle hp events arrive (`FIFO_DEPTH`=4) → 4 records held, 2 dropped, `overflow`=1. The next record after draining has mask 0x84.
- `tx_ready` toggled every other cycle → `tx_data` stable across stalls, 8 bytes per record in order, no duplicates.
- `finish`=1 with `r`=0x0029 at cycle 100, then more `h` changes → record mask 0x08 with bytes 6–7 = `00 29`. `done` rises on its byte-7 handshake. No further records.
- `reset_n` pulsed low at byte 3 of a record → `tx_valid`=0 and all outputs 0 immediately. After release, the stream restarts clean with `cycle`=0.
